// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 do/redo loop cache.
package jtdsp16_pkg;

    typedef enum logic [1:0] {
        DO_IDLE   = 2'd0,
        DO_LOAD   = 2'd1,
        DO_REPLAY = 2'd2
    } do_state_t;

    // Field positions inside the decoder's do_data word: [10:7]=N, [6:0]=K
    localparam int DO_N_MSB = 10;
    localparam int DO_N_LSB = 7;
    localparam int DO_K_MSB = 6;
    localparam int DO_NW    = DO_N_MSB - DO_N_LSB + 1;

endpackage

// File: rtl/jtdsp16_do_mem.sv
// Small register file holding the captured loop body.
// One synchronous write port and one asynchronous read port.
module jtdsp16_do_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Capture a ROM word into the addressed slot; out-of-range slots are ignored
    always_ff @(posedge clk) begin
        if (we && (waddr < AW'(DEPTH))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/jtdsp16_do_cache.sv
// DSP16 "do K {N instr}" / "redo K" loop engine.
// The first pass captures the loop body from ROM, later passes replay it
// from the internal cache while the XAAU program counter is held.
module jtdsp16_do_cache #(
    parameter int DW    = 16,
    parameter int DEPTH = 15,
    parameter int KW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          do_start,
    input  logic [10:0]   do_data,
    input  logic          fetch_adv,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] cache_dout,
    output logic          up_xcache,
    output logic          pc_hold,
    output logic          busy,
    output logic          fault
);

    import jtdsp16_pkg::*;

    localparam int AW = DO_NW;

    do_state_t         state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     nlen;
    logic [KW-1:0]     kcnt;
    logic              valid;

    logic [AW-1:0]     do_n;
    logic [DO_K_MSB:0] do_k;
    logic              last_slot;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;

    assign do_n      = do_data[DO_N_MSB:DO_N_LSB];
    assign do_k      = do_data[DO_K_MSB:0];
    assign last_slot = (ptr == (nlen - AW'(1)));
    assign mem_we    = rst_n & cen & fetch_adv & (state == DO_LOAD);

    // The cache is only visible to the decoder while a replay is running
    assign cache_dout = up_xcache ? mem_rdata : '0;

    jtdsp16_do_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (rom_dout),
        .raddr (ptr),
        .rdata (mem_rdata)
    );

    // Loop FSM: slot pointer, pass counter and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DO_IDLE;
            ptr       <= '0;
            nlen      <= '0;
            kcnt      <= '0;
            valid     <= 1'b0;
            up_xcache <= 1'b0;
            pc_hold   <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else if (cen) begin
            fault <= 1'b0;
            case (state)
                DO_IDLE: begin
                    if (do_start) begin
                        if ((do_n != '0) && (do_k != '0)) begin
                            nlen  <= do_n;
                            kcnt  <= KW'(do_k);
                            ptr   <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b1;
                            state <= DO_LOAD;
                        end else if ((do_n == '0) && valid && (do_k != '0)) begin
                            kcnt      <= KW'(do_k);
                            ptr       <= '0;
                            busy      <= 1'b1;
                            up_xcache <= 1'b1;
                            pc_hold   <= 1'b1;
                            state     <= DO_REPLAY;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                DO_LOAD: begin
                    if (do_start) begin
                        fault <= 1'b1;
                    end
                    if (fetch_adv) begin
                        if (last_slot) begin
                            valid <= 1'b1;
                            ptr   <= '0;
                            if (kcnt == KW'(1)) begin
                                busy  <= 1'b0;
                                state <= DO_IDLE;
                            end else begin
                                kcnt      <= kcnt - KW'(1);
                                up_xcache <= 1'b1;
                                pc_hold   <= 1'b1;
                                state     <= DO_REPLAY;
                            end
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                DO_REPLAY: begin
                    if (do_start) begin
                        fault <= 1'b1;
                    end
                    if (fetch_adv) begin
                        if (last_slot) begin
                            ptr <= '0;
                            if (kcnt == KW'(1)) begin
                                busy      <= 1'b0;
                                up_xcache <= 1'b0;
                                pc_hold   <= 1'b0;
                                state     <= DO_IDLE;
                            end else begin
                                kcnt <= kcnt - KW'(1);
                            end
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= DO_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Testbench for jtdsp16_do_cache: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked against a
// behavioural loop model.
module tb_jtdsp16_do_cache;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic          do_start = 1'b0;
    logic [10:0]   do_data = '0;
    logic          fetch_adv = 1'b0;
    logic [DW-1:0] rom_dout = '0;
    logic [DW-1:0] cache_dout;
    logic          up_xcache;
    logic          pc_hold;
    logic          busy;
    logic          fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] w [3];

    jtdsp16_do_cache #(.DW(DW), .DEPTH(15), .KW(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .do_start   (do_start),
        .do_data    (do_data),
        .fetch_adv  (fetch_adv),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .up_xcache  (up_xcache),
        .pc_hold    (pc_hold),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: a loop is a run of N*K fetches, the first N of
    // which come from ROM (when loading) and the rest from the stored body.
    bit            m_busy, m_replay, m_loading, m_fault, m_valid;
    int            m_len, m_new_len, m_pos, m_total;
    logic [DW-1:0] m_body [$];
    logic [DW-1:0] m_new  [$];

    task automatic model_step();
        bit was_busy;
        int n, k;
        if (!rst_n) begin
            m_busy = 0; m_replay = 0; m_loading = 0; m_fault = 0; m_valid = 0;
        end else if (cen) begin
            was_busy = m_busy;
            n = int'(do_data[10:7]);
            k = int'(do_data[6:0]);
            m_fault = 0;
            if (do_start) begin
                if (was_busy) begin
                    m_fault = 1;
                end else if (n != 0 && k != 0) begin
                    m_busy = 1; m_loading = 1; m_replay = 0; m_valid = 0;
                    m_new_len = n; m_new.delete(); m_pos = 0; m_total = n * k;
                end else if (n == 0 && k != 0 && m_valid) begin
                    m_busy = 1; m_replay = 1; m_pos = 0; m_total = m_len * k;
                end else begin
                    m_fault = 1;
                end
            end
            if (fetch_adv && was_busy) begin
                m_pos++;
                if (m_loading) begin
                    m_new.push_back(rom_dout);
                    if (m_pos == m_new_len) begin
                        m_loading = 0; m_valid = 1;
                        m_body = m_new; m_len = m_new_len;
                        if (m_pos == m_total) m_busy = 0;
                        else m_replay = 1;
                    end
                end else if (m_pos == m_total) begin
                    m_busy = 0; m_replay = 0;
                end
            end
        end
    endtask

    // Drive one clock's worth of inputs at the falling edge, advance the
    // model at the rising edge and leave time just past it for checks
    task automatic apply_stimulus(input bit r, input bit c, input bit ds,
                                  input logic [10:0] dd, input bit fa,
                                  input logic [DW-1:0] rom);
        @(negedge clk);
        rst_n = r; cen = c; do_start = ds; do_data = dd;
        fetch_adv = fa; rom_dout = rom;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input bit x, input bit h,
                                input bit b, input bit f, input logic [DW-1:0] d);
        check_val({name, ".up_xcache"}, 32'(up_xcache), 32'(x));
        check_val({name, ".pc_hold"},   32'(pc_hold),   32'(h));
        check_val({name, ".busy"},      32'(busy),      32'(b));
        check_val({name, ".fault"},     32'(fault),     32'(f));
        check_val({name, ".cache_dout"}, 32'(cache_dout), 32'(d));
    endtask

    task automatic check_model(input string name);
        logic [DW-1:0] d;
        d = m_replay ? m_body[m_pos % m_len] : '0;
        check_output(name, m_replay, m_replay, m_busy, m_fault, d);
    endtask

    typedef struct {
        bit            r;
        bit            ds;
        logic [10:0]   dd;
        bit            fa;
        logic [DW-1:0] rom;
        bit            x;
        bit            b;
        bit            f;
        logic [DW-1:0] d;
    } vec_t;

    function automatic vec_t mk(bit r, bit ds, logic [10:0] dd, bit fa,
                                logic [DW-1:0] rom, bit x, bit b, bit f,
                                logic [DW-1:0] d);
        vec_t v;
        v.r = r; v.ds = ds; v.dd = dd; v.fa = fa; v.rom = rom;
        v.x = x; v.b = b; v.f = f; v.d = d;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [$];
        logic [DW-1:0] A, B, C, D, E, J;
        bit x, b;
        logic [DW-1:0] d;
        A = 16'hA1A1; B = 16'hB2B2; C = 16'hC3C3;
        D = 16'hD4D4; E = 16'hE5E5; J = 16'h5A5A;
        w[0] = A; w[1] = B; w[2] = C;

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(0, 0, 11'd0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, {4'd3, 7'd0}, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 11'd0,        0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, {4'd0, 7'd5}, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, {4'd3, 7'd4}, 1, J, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, A, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, B, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, C, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        0, J, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, B));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, C));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, B));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, C));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, B));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, C));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, {4'd0, 7'd2}, 0, 0, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, B));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, C));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, A));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, B));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, C));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, {4'd2, 7'd1}, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, D, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 11'd0,        1, E, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, {4'd0, 7'd2}, 0, 0, 1, 1, 0, D));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, E));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, D));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 1, 1, 0, E));
        vecs.push_back(mk(1, 0, 11'd0,        1, J, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].r, 1'b1, vecs[i].ds, vecs[i].dd,
                           vecs[i].fa, vecs[i].rom);
            check_output($sformatf("vec%0d", i), vecs[i].x, vecs[i].x,
                         vecs[i].b, vecs[i].f, vecs[i].d);
        end

        // ---------------- nested do during replay ----------------
        apply_stimulus(1, 1, 1, {4'd3, 7'd4}, 0, 0);
        check_output("s4_start", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 11'd0, 1, w[i]);
        check_output("s4_loaded", 1, 1, 1, 0, A);
        for (int j = 1; j <= 9; j++) begin
            apply_stimulus(1, 1, (j == 2), {4'd2, 7'd3}, 1, J);
            if (j < 9) check_output($sformatf("s4_rep%0d", j), 1, 1, 1, (j == 2), w[j % 3]);
            else       check_output("s4_end", 0, 0, 0, 0, 0);
        end

        // ---------------- reset in the middle of a replay ----------------
        apply_stimulus(1, 1, 1, {4'd3, 7'd2}, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 11'd0, 1, w[i]);
        apply_stimulus(1, 1, 0, 11'd0, 1, J);
        check_output("s5_replaying", 1, 1, 1, 0, B);
        apply_stimulus(0, 1, 0, 11'd0, 1, J);
        check_output("s5_reset", 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, {4'd0, 7'd5}, 0, 0);
        check_output("s5_redo_fault", 0, 0, 0, 1, 0);
        apply_stimulus(1, 1, 0, 11'd0, 1, J);
        check_output("s5_idle", 0, 0, 0, 0, 0);

        // ---------------- clock-enable gaps with fetch held high ----------------
        apply_stimulus(1, 1, 1, {4'd3, 7'd4}, 0, 0);
        for (int f = 1; f <= 12; f++) begin
            if (f < 3)       begin x = 0; b = 1; d = '0; end
            else if (f < 12) begin x = 1; b = 1; d = w[(f - 3) % 3]; end
            else             begin x = 0; b = 0; d = '0; end
            apply_stimulus(1, 0, 0, 11'd0, 1, J);
            apply_stimulus(1, 1, 0, 11'd0, 1, (f <= 3) ? w[f - 1] : J);
            check_output($sformatf("s6_fetch%0d", f), x, x, b, 0, d);
        end

        // ---------------- randomized traffic against the model ----------------
        apply_stimulus(0, 1, 0, 11'd0, 0, 0);
        check_model("rand_reset");
        for (int i = 0; i < 4000; i++) begin
            bit r, c, ds, fa;
            int n, k;
            r  = ($urandom_range(0, 199) != 0);
            c  = ($urandom_range(0, 3) != 0);
            ds = ($urandom_range(0, 19) == 0);
            fa = ($urandom_range(0, 2) != 0);
            n  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            k  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
            apply_stimulus(r, c, ds, {4'(n), 7'(k)}, fa, 16'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
